// File: rtl/array_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : array_ctrl_if
//  Description : Scheduler-to-sequencer handshake and systolic array
//                enable/clear control bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface array_ctrl_if #(
    parameter int HEIGHT = 12,
    parameter int WIDTH  = 14,
    parameter int KW     = 16
);
    logic              start;
    logic [KW-1:0]     cfg_k;
    logic              cfg_reuse_w;
    logic              abort;
    logic              ready;
    logic              busy;
    logic              done;
    logic [HEIGHT-1:0] en_i;
    logic [HEIGHT-1:0] clr_i;
    logic [WIDTH-1:0]  en_w;
    logic [WIDTH-1:0]  clr_w;
    logic [WIDTH-1:0]  en_o;
    logic [WIDTH-1:0]  clr_o;

    modport master (
        output start, cfg_k, cfg_reuse_w, abort,
        input  ready, busy, done, en_i, clr_i, en_w, clr_w, en_o, clr_o
    );

    modport slave (
        input  start, cfg_k, cfg_reuse_w, abort,
        output ready, busy, done, en_i, clr_i, en_w, clr_w, en_o, clr_o
    );
endinterface
`default_nettype wire

// File: rtl/array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : array_ctrl
//  Description : Tile sequencer for a HEIGHT x WIDTH systolic array: weight
//                load, skewed input streaming and per-column output windows.
//  Revision    : 1.0 - initial release
// ============================================================================
module array_ctrl #(
    parameter int HEIGHT = 12,
    parameter int WIDTH  = 14,
    parameter int KW     = 16
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    array_ctrl_if.slave     bus
);

    localparam int c_HW_BITS = $clog2(HEIGHT + WIDTH);
    localparam int c_TW      = ((KW > c_HW_BITS) ? KW : c_HW_BITS) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WLOAD  = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_TW-1:0]   r_t;
    logic [c_TW-1:0]   w_t_nxt;
    logic [KW-1:0]     r_k;
    logic [KW-1:0]     w_k_nxt;
    logic [c_TW-1:0]   w_k_ext;
    logic [c_TW-1:0]   w_last_wload;
    logic [c_TW-1:0]   w_last_stream;
    logic              w_accept;
    logic              w_wload_nxt;
    logic              w_stream_nxt;

    logic [HEIGHT-1:0] w_en_i, w_clr_i;
    logic [WIDTH-1:0]  w_en_o, w_clr_o;

    logic              r_ready, r_busy, r_done;
    logic [HEIGHT-1:0] r_en_i, r_clr_i;
    logic [WIDTH-1:0]  r_en_w, r_clr_w, r_en_o, r_clr_o;

    assign w_accept      = bus.start && !bus.abort && (r_state == S_IDLE);
    assign w_k_nxt       = w_accept ? bus.cfg_k : r_k;
    assign w_k_ext       = c_TW'(w_k_nxt);
    assign w_last_wload  = c_TW'(HEIGHT - 1);
    assign w_last_stream = c_TW'(r_k) + c_TW'(HEIGHT + WIDTH - 3);

    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.cfg_k == '0)
                        w_state_nxt = S_DONE;
                    else if (bus.cfg_reuse_w)
                        w_state_nxt = S_STREAM;
                    else
                        w_state_nxt = S_WLOAD;
                end
            end
            S_WLOAD: begin
                if (bus.abort)
                    w_state_nxt = S_IDLE;
                else if (r_t == w_last_wload)
                    w_state_nxt = S_STREAM;
                else
                    w_t_nxt = r_t + c_TW'(1);
            end
            S_STREAM: begin
                if (bus.abort)
                    w_state_nxt = S_IDLE;
                else if (r_t == w_last_stream)
                    w_state_nxt = S_DONE;
                else
                    w_t_nxt = r_t + c_TW'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_wload_nxt  = (w_state_nxt == S_WLOAD);
    assign w_stream_nxt = (w_state_nxt == S_STREAM);

    // Window test (t - off) < K: when t < off the difference wraps above 2^KW-1,
    // because the counter carries a spare bit over both KW and the skew range.
    generate
        for (genvar h = 0; h < HEIGHT; h++) begin : g_row
            localparam logic [c_TW-1:0] c_OFF = c_TW'(h);
            assign w_en_i[h]  = w_stream_nxt && ((w_t_nxt - c_OFF) < w_k_ext);
            assign w_clr_i[h] = w_stream_nxt && (w_t_nxt == c_OFF);
        end
        for (genvar w = 0; w < WIDTH; w++) begin : g_col
            localparam logic [c_TW-1:0] c_OFF = c_TW'(w + HEIGHT - 1);
            assign w_en_o[w]  = w_stream_nxt && ((w_t_nxt - c_OFF) < w_k_ext);
            assign w_clr_o[w] = w_stream_nxt && (w_t_nxt == c_OFF);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_t     <= '0;
            r_k     <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_en_i  <= '0;
            r_clr_i <= '0;
            r_en_w  <= '0;
            r_clr_w <= '0;
            r_en_o  <= '0;
            r_clr_o <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
            if (w_accept)
                r_k <= bus.cfg_k;
            r_ready <= (w_state_nxt == S_IDLE);
            r_busy  <= w_wload_nxt || w_stream_nxt;
            r_done  <= (w_state_nxt == S_DONE);
            r_en_i  <= w_en_i;
            r_clr_i <= w_clr_i;
            r_en_w  <= {WIDTH{w_wload_nxt}};
            r_clr_w <= {WIDTH{w_wload_nxt && (w_t_nxt == '0)}};
            r_en_o  <= w_en_o;
            r_clr_o <= w_clr_o;
        end
    end

    assign bus.ready = r_ready;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.en_i  = r_en_i;
    assign bus.clr_i = r_clr_i;
    assign bus.en_w  = r_en_w;
    assign bus.clr_w = r_clr_w;
    assign bus.en_o  = r_en_o;
    assign bus.clr_o = r_clr_o;

endmodule
`default_nettype wire

// File: tb/tb_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_array_ctrl
//  Description : Bench for array_ctrl: timeline model of each tile plus
//                directed literal checks of the key cycle positions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_array_ctrl;

    localparam int H  = 12;
    localparam int W  = 14;
    localparam int KW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    array_ctrl_if #(.HEIGHT(H), .WIDTH(W), .KW(KW)) bus ();

    array_ctrl #(.HEIGHT(H), .WIDTH(W), .KW(KW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;
    longint t_acc  = 0;

    // Model: one in-flight tile described by its accept cycle and config
    bit     m_inflight = 1'b0;
    longint m_acc      = 0;
    longint m_k        = 0;
    bit     m_reuse    = 1'b0;

    longint done_cnt  = 0;
    longint win_cnt   = 0;
    longint en_hi_cnt = 0;
    longint en_w_cnt  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic longint f_s(bit reuse);
        return reuse ? 64'd1 : 64'(H + 1);
    endfunction

    function automatic longint f_l(longint k);
        return k + H + W - 2;
    endfunction

    function automatic longint f_end(longint k, bit reuse);
        return (k == 0) ? 64'd1 : f_s(reuse) + f_l(k);
    endfunction

    function automatic bit m_idle_at(longint c);
        return !m_inflight || ((c - m_acc) > f_end(m_k, m_reuse));
    endfunction

    always @(posedge clk) begin
        if (!rst_n)
            m_inflight <= 1'b0;
        else if (m_idle_at(cyc)) begin
            if (bus.start && !bus.abort) begin
                m_inflight <= 1'b1;
                m_acc      <= cyc;
                m_k        <= longint'(bus.cfg_k);
                m_reuse    <= bus.cfg_reuse_w;
            end
        end else if (bus.abort)
            m_inflight <= 1'b0;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin : p_compare
        logic          e_ready, e_busy, e_done, wload, stream;
        logic [H-1:0]  e_en_i, e_clr_i;
        logic [W-1:0]  e_en_w, e_clr_w, e_en_o, e_clr_o;
        longint        rel, t, s, l;
        e_ready = 1'b1; e_busy = 1'b0; e_done = 1'b0; wload = 1'b0; stream = 1'b0;
        e_en_i = '0; e_clr_i = '0; e_en_w = '0; e_clr_w = '0; e_en_o = '0; e_clr_o = '0;
        rel = 0; t = 0;
        s = f_s(m_reuse);
        l = f_l(m_k);
        if (rst_n && !m_idle_at(cyc)) begin
            rel     = cyc - m_acc;
            e_ready = 1'b0;
            e_done  = (rel == f_end(m_k, m_reuse));
            wload   = !m_reuse && (m_k != 0) && (rel <= H);
            stream  = (m_k != 0) && (rel >= s) && (rel < s + l);
            t       = rel - s;
            e_busy  = wload || stream;
        end
        if (wload) e_en_w = '1;
        if (wload && rel == 1) e_clr_w = '1;
        for (int h = 0; h < H; h++) begin
            e_en_i[h]  = stream && (t >= h) && (t < h + m_k);
            e_clr_i[h] = stream && (t == h);
        end
        for (int w = 0; w < W; w++) begin
            e_en_o[w]  = stream && (t >= w + H - 1) && (t < w + H - 1 + m_k);
            e_clr_o[w] = stream && (t == w + H - 1);
        end
        chk("ready", bus.ready, e_ready);
        chk("busy",  bus.busy,  e_busy);
        chk("done",  bus.done,  e_done);
        chk("en_i",  bus.en_i,  e_en_i);
        chk("clr_i", bus.clr_i, e_clr_i);
        chk("en_w",  bus.en_w,  e_en_w);
        chk("clr_w", bus.clr_w, e_clr_w);
        chk("en_o",  bus.en_o,  e_en_o);
        chk("clr_o", bus.clr_o, e_clr_o);
        if (bus.done)     done_cnt  <= done_cnt + 1;
        if (bus.en_i[0])  win_cnt   <= win_cnt + 1;
        if (|bus.en_w)    en_w_cnt  <= en_w_cnt + 1;
        if ((|bus.en_i) || (|bus.en_w) || (|bus.en_o)) en_hi_cnt <= en_hi_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go_rel(input longint r);
        while (cyc - t_acc < r) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_rel(input longint r);
        go_rel(r);
        @(negedge clk);
    endtask

    task automatic start_tile(input logic [KW-1:0] k, input bit reuse);
        bus.start       = 1'b1;
        bus.cfg_k       = k;
        bus.cfg_reuse_w = reuse;
        t_acc           = cyc;
        tick(1);
        bus.start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

    initial begin
        longint d0, w0, e0;
        bus.start = 1'b0; bus.cfg_k = '0; bus.cfg_reuse_w = 1'b0; bus.abort = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(10);
        @(negedge clk);
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_busy",  bus.busy,  1'b0);
        chk("rst_vec",   {bus.en_i, bus.clr_i, bus.en_w, bus.clr_w, bus.en_o, bus.clr_o}, 64'd0);

        // Full tile K=4 with weight load
        tick(1);
        d0 = done_cnt;
        start_tile(16'd4, 1'b0);
        at_rel(1);  chk("full_enw_c1", bus.en_w, 14'h3FFF); chk("full_clrw_c1", bus.clr_w, 14'h3FFF);
        at_rel(2);  chk("full_clrw_c2", bus.clr_w, 14'h0);
        at_rel(12); chk("full_enw_c12", bus.en_w, 14'h3FFF); chk("full_eni_c12", bus.en_i, 12'h0);
        at_rel(13); chk("full_enw_c13", bus.en_w, 14'h0); chk("full_eni0_c13", bus.en_i[0], 1'b1);
        at_rel(16); chk("full_eni0_c16", bus.en_i[0], 1'b1);
        at_rel(17); chk("full_eni0_c17", bus.en_i[0], 1'b0);
        at_rel(24); chk("full_eni11_c24", bus.en_i[11], 1'b1); chk("full_eno0_c24", bus.en_o[0], 1'b1);
        at_rel(27); chk("full_eni11_c27", bus.en_i[11], 1'b1); chk("full_eno0_c27", bus.en_o[0], 1'b1);
        at_rel(28); chk("full_eno0_c28", bus.en_o[0], 1'b0);
        at_rel(37); chk("full_eno13_c37", bus.en_o[13], 1'b1);
        at_rel(40); chk("full_eno13_c40", bus.en_o[13], 1'b1); chk("full_done_c40", bus.done, 1'b0);
        at_rel(41); chk("full_done_c41", bus.done, 1'b1); chk("full_ready_c41", bus.ready, 1'b0);
        at_rel(42); chk("full_ready_c42", bus.ready, 1'b1);
        tick(1);
        chk("full_done_count", done_cnt - d0, 64'd1);

        // Reuse weights, K=1
        w0 = en_w_cnt;
        start_tile(16'd1, 1'b1);
        at_rel(25); chk("reuse_clro13_c25", bus.clr_o[13], 1'b1);
        at_rel(26); chk("reuse_done_c26", bus.done, 1'b1);
        tick(2);
        chk("reuse_enw_never", en_w_cnt - w0, 64'd0);

        // K=0
        e0 = en_hi_cnt;
        start_tile(16'd0, 1'b0);
        at_rel(1); chk("k0_done_c1", bus.done, 1'b1); chk("k0_busy_c1", bus.busy, 1'b0);
        at_rel(2); chk("k0_ready_c2", bus.ready, 1'b1);
        tick(1);
        chk("k0_no_enable", en_hi_cnt - e0, 64'd0);

        // K=0xFFFF: long window without counter wrap
        w0 = win_cnt;
        start_tile(16'hFFFF, 1'b1);
        at_rel(65560); chk("kmax_done", bus.done, 1'b1);
        tick(2);
        chk("kmax_eni0_window", win_cnt - w0, 64'd65535);

        // Abort at STREAM t=5, then restart one cycle later
        tick(1);
        d0 = done_cnt;
        start_tile(16'd4, 1'b1);
        go_rel(6);
        bus.abort = 1'b1;
        go_rel(7);
        bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_vec", {bus.en_i, bus.clr_i, bus.en_w, bus.clr_w, bus.en_o, bus.clr_o}, 64'd0);
        chk("abort_ready", bus.ready, 1'b1);
        chk("abort_done", bus.done, 1'b0);
        start_tile(16'd4, 1'b1);
        at_rel(1); chk("restart_busy", bus.busy, 1'b1);
        at_rel(30); chk("restart_ready", bus.ready, 1'b1);
        tick(1);
        chk("abort_done_count", done_cnt - d0, 64'd1);

        // Abort in IDLE masks a simultaneous start
        bus.start = 1'b1; bus.abort = 1'b1; bus.cfg_k = 16'd3; bus.cfg_reuse_w = 1'b0;
        tick(1);
        bus.start = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_ready", bus.ready, 1'b1);
        chk("idle_abort_busy", bus.busy, 1'b0);

        // Asynchronous reset mid-WLOAD
        tick(1);
        d0 = done_cnt;
        start_tile(16'd3, 1'b0);
        go_rel(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_enw", bus.en_w, 14'h0);
        chk("areset_busy", bus.busy, 1'b0);
        chk("areset_ready", bus.ready, 1'b1);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("areset_no_done", done_cnt - d0, 64'd0);

        // start held high while busy
        d0 = done_cnt;
        bus.start = 1'b1; bus.cfg_k = 16'd2; bus.cfg_reuse_w = 1'b1;
        t_acc = cyc;
        go_rel(27);
        bus.start = 1'b0;
        go_rel(30);
        chk("held_done_count", done_cnt - d0, 64'd1);
        chk("held_ready", bus.ready, 1'b1);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
